// File: rtl/updown_mod_counter.sv
// Parametrised modulo up/down counter with wrap/saturate mode, count enable,
// synchronous clamped parallel load, combinational terminal flag and registered wrap pulse.
module updown_mod_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 16,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             DIRECTION,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  output logic [WIDTH-1:0] COUNT_OUT,
  output logic             TERMINAL,
  output logic             WRAPPED
);

  // Reject illegal parameter sets at elaboration.
  if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH) ||
      RESET_VALUE >= MODULUS) begin : g_bad_params
    $fatal(1, "updown_mod_counter: illegal parameters WIDTH=%0d MODULUS=%0d RESET_VALUE=%0d",
           WIDTH, MODULUS, RESET_VALUE);
  end

  localparam logic [WIDTH-1:0] MaxCount   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrapped_d, wrapped_q;
  logic             at_max, at_min;

  assign at_max = (count_q == MaxCount);
  assign at_min = (count_q == '0);

  // Range ends are detected by explicit compare so MODULUS == 2**WIDTH behaves the same.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (LOAD) begin
      count_d = (LOAD_VALUE > MaxCount) ? MaxCount : LOAD_VALUE;
    end else if (ENABLE) begin
      if (DIRECTION) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (!SATURATE) begin
          count_d   = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - WIDTH'(1);
        end else if (!SATURATE) begin
          count_d   = MaxCount;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_q   <= ResetCount;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign COUNT_OUT = count_q;
  assign WRAPPED   = wrapped_q;
  assign TERMINAL  = DIRECTION ? at_max : at_min;

endmodule
